// File: rtl/pipe_perf_pkg.sv
// Shared types and constants for the pipeline performance monitor.
package pipe_perf_pkg;

  // Default counter width.
  localparam int unsigned DefCntW = 32;

  // Monitor run state.
  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Readout select codes; 6 and 7 read as zero.
  localparam logic [2:0] SEL_CYCLE  = 3'd0;
  localparam logic [2:0] SEL_STALL  = 3'd1;
  localparam logic [2:0] SEL_FLUSH  = 3'd2;
  localparam logic [2:0] SEL_RETIRE = 3'd3;
  localparam logic [2:0] SEL_MAXRUN = 3'd4;
  localparam logic [2:0] SEL_STATUS = 3'd5;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and an overflow pulse.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_max;

  assign at_max = &cnt_q;

  // Next value: clear wins, then increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_max) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  // Pulses when an increment is attempted at the ceiling.
  assign ovf_o = inc_i & at_max & ~clr_i;

endmodule

// File: rtl/pipe_perf_monitor.sv
// Counts cycles, qualified stalls, flushes, retirements and the longest
// stall burst of the CPU pipeline, stopping after a programmed cycle budget.
module pipe_perf_monitor
  import pipe_perf_pkg::*;
#(
  parameter int unsigned CNT_W       = DefCntW,
  parameter int unsigned CYCLE_LIMIT = 30
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             flush_i,
  input  logic             retire_i,
  input  logic             clear_i,
  input  logic [2:0]       sel_i,
  output logic [CNT_W-1:0] rd_data_o,
  output logic             done_o,
  output logic             ovf_o
);

  // A limit the counter can never reach would otherwise alias after truncation.
  localparam bit LimitFits = (CNT_W >= 32) || (64'(CYCLE_LIMIT) < (64'd1 << CNT_W));
  localparam bit LimitOn   = (CYCLE_LIMIT != 0) && LimitFits;
  localparam logic [CNT_W-1:0] LimitM1 = CNT_W'(CYCLE_LIMIT - 1);

  state_e           state_q, state_d;
  logic             clr_all;
  logic             count_en;
  logic             qual_stall;
  logic             limit_hit;
  logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt, retire_cnt, run_cnt;
  logic             cycle_ovf, stall_ovf, flush_ovf, retire_ovf, run_ovf;
  logic [CNT_W-1:0] run_next;
  logic [CNT_W-1:0] max_run_q;
  logic             ovf_q;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;

  assign clr_all    = rst_i | clear_i;
  // The IDLE->RUN edge is itself a counted cycle; DONE counts nothing.
  assign count_en   = start_i & (state_q != StDone);
  assign qual_stall = stall_i & ~branch_i;
  assign limit_hit  = LimitOn && count_en && (cycle_cnt == LimitM1);

  sat_counter #(.CNT_W(CNT_W)) u_cycle (
    .clk_i (clk_i),
    .clr_i (clr_all),
    .inc_i (count_en),
    .cnt_o (cycle_cnt),
    .ovf_o (cycle_ovf)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clk_i (clk_i),
    .clr_i (clr_all),
    .inc_i (count_en & qual_stall),
    .cnt_o (stall_cnt),
    .ovf_o (stall_ovf)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush (
    .clk_i (clk_i),
    .clr_i (clr_all),
    .inc_i (count_en & flush_i),
    .cnt_o (flush_cnt),
    .ovf_o (flush_ovf)
  );

  sat_counter #(.CNT_W(CNT_W)) u_retire (
    .clk_i (clk_i),
    .clr_i (clr_all),
    .inc_i (count_en & retire_i),
    .cnt_o (retire_cnt),
    .ovf_o (retire_ovf)
  );

  // Current stall burst: restarts on any counted non-stall cycle.
  sat_counter #(.CNT_W(CNT_W)) u_run (
    .clk_i (clk_i),
    .clr_i (clr_all | (count_en & ~qual_stall)),
    .inc_i (count_en & qual_stall),
    .cnt_o (run_cnt),
    .ovf_o (run_ovf)
  );

  // Mirror of the burst counter's next value so the max sees an open burst.
  always_comb begin
    run_next = run_cnt;
    if (count_en) begin
      if (!qual_stall) begin
        run_next = '0;
      end else if (!(&run_cnt)) begin
        run_next = run_cnt + CNT_W'(1);
      end
    end
  end

  // Longest burst seen so far.
  always_ff @(posedge clk_i) begin
    if (clr_all) begin
      max_run_q <= '0;
    end else if (count_en && (run_next > max_run_q)) begin
      max_run_q <= run_next;
    end
  end

  // Sticky overflow flag.
  always_ff @(posedge clk_i) begin
    if (clr_all) begin
      ovf_q <= 1'b0;
    end else if (cycle_ovf | stall_ovf | flush_ovf | retire_ovf | run_ovf) begin
      ovf_q <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear returns to IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = limit_hit ? StDone : StRun;
      StRun:   if (limit_hit) state_d = StDone;
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
    if (clear_i) begin
      state_d = StIdle;
    end
  end

  // Readout mux of pre-edge values.
  always_comb begin
    rd_data_d = '0;
    case (sel_i)
      SEL_CYCLE:  rd_data_d = cycle_cnt;
      SEL_STALL:  rd_data_d = stall_cnt;
      SEL_FLUSH:  rd_data_d = flush_cnt;
      SEL_RETIRE: rd_data_d = retire_cnt;
      SEL_MAXRUN: rd_data_d = max_run_q;
      SEL_STATUS: rd_data_d[1:0] = {ovf_q, state_q == StDone};
      default:    rd_data_d = '0;
    endcase
  end

  // Registered readout, live in every state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign done_o    = (state_q == StDone);
  assign ovf_o     = ovf_q;

endmodule
